// File: rtl/wb_port_arbiter_if.sv
// Bundle for the write-back port arbiter: two requesters, the register-file
// write port and the outstanding-write scoreboard.
interface wb_port_arbiter_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15
);
    logic                a_valid;
    logic [3:0]          a_dest;
    logic [DATA_W-1:0]   a_value;
    logic                a_ready;
    logic                b_valid;
    logic [3:0]          b_dest;
    logic [DATA_W-1:0]   b_value;
    logic                b_ready;
    logic                b_issue;
    logic [3:0]          b_issue_dest;
    logic                WB_WB_EN;
    logic [3:0]          WB_Dest;
    logic [DATA_W-1:0]   WB_Value;
    logic [NUM_REGS-1:0] pending;
    logic                dest_err;

    modport master (
        output a_valid, a_dest, a_value, b_valid, b_dest, b_value, b_issue, b_issue_dest,
        input  a_ready, b_ready, WB_WB_EN, WB_Dest, WB_Value, pending, dest_err
    );

    modport slave (
        input  a_valid, a_dest, a_value, b_valid, b_dest, b_value, b_issue, b_issue_dest,
        output a_ready, b_ready, WB_WB_EN, WB_Dest, WB_Value, pending, dest_err
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one registered register-file write port between the
// pipeline WB stage (A) and a multi-cycle unit (B), with a pending-write scoreboard for B.
module wb_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15
) (
    input logic              clk,
    input logic              rst,
    wb_port_arbiter_if.slave bus
);
    localparam logic        GNT_A      = 1'b0;
    localparam logic        GNT_B      = 1'b1;
    localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

    logic                last_grant_q, last_grant_d;
    logic                wb_en_q, wb_en_d;
    logic [3:0]          wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0]   wb_value_q, wb_value_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                dest_err_q, dest_err_d;

    logic                grant_a, grant_b;
    logic                xfer, xfer_ok;
    logic [3:0]          xfer_dest;
    logic [DATA_W-1:0]   xfer_value;

    function automatic logic dest_in_range(input logic [3:0] d);
        return {28'd0, d} < NUM_REGS_U;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GNT_B;
            wb_en_q      <= 1'b0;
            wb_dest_q    <= '0;
            wb_value_q   <= '0;
            pending_q    <= '0;
            dest_err_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            wb_en_q      <= wb_en_d;
            wb_dest_q    <= wb_dest_d;
            wb_value_q   <= wb_value_d;
            pending_q    <= pending_d;
            dest_err_q   <= dest_err_d;
        end
    end

    // Next state
    always_comb begin
        last_grant_d = last_grant_q;
        wb_en_d      = 1'b0;
        wb_dest_d    = wb_dest_q;
        wb_value_d   = wb_value_q;
        pending_d    = pending_q;
        dest_err_d   = dest_err_q;
        xfer         = grant_a | grant_b;
        xfer_dest    = grant_a ? bus.a_dest  : bus.b_dest;
        xfer_value   = grant_a ? bus.a_value : bus.b_value;
        xfer_ok      = dest_in_range(xfer_dest);

        if (grant_a) begin
            last_grant_d = GNT_A;
        end else if (grant_b) begin
            last_grant_d = GNT_B;
        end

        // Out-of-range destinations are still handshaken but never reach the register file.
        if (xfer && xfer_ok) begin
            wb_en_d    = 1'b1;
            wb_dest_d  = xfer_dest;
            wb_value_d = xfer_value;
        end
        if (xfer && !xfer_ok) begin
            dest_err_d = 1'b1;
        end

        // Set after clear so a same-register issue overrides the retiring write.
        for (int r = 0; r < NUM_REGS; r++) begin
            if (grant_b && bus.b_dest == 4'(r)) begin
                pending_d[r] = 1'b0;
            end
            if (bus.b_issue && bus.b_issue_dest == 4'(r)) begin
                pending_d[r] = 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (bus.a_valid && bus.b_valid) begin
                grant_a = (last_grant_q == GNT_B);
                grant_b = (last_grant_q == GNT_A);
            end else begin
                grant_a = bus.a_valid;
                grant_b = bus.b_valid;
            end
        end
    end

    assign bus.a_ready  = grant_a;
    assign bus.b_ready  = grant_b;
    assign bus.WB_WB_EN = wb_en_q;
    assign bus.WB_Dest  = wb_dest_q;
    assign bus.WB_Value = wb_value_q;
    assign bus.pending  = pending_q;
    assign bus.dest_err = dest_err_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios plus a random run.
module tb_wb_port_arbiter;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 15;

    typedef struct {
        logic              en;
        logic [3:0]        dest;
        logic [DATA_W-1:0] value;
        logic              chk_dv;
    } wb_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) bus ();

    wb_port_arbiter #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_exp_t             sb_q[$];
    int                  n_chk  = 0;
    int                  n_pass = 0;
    logic                m_last = 1'b1;
    logic                m_en   = 1'b0;
    logic [3:0]          m_dest = '0;
    logic [DATA_W-1:0]   m_val  = '0;
    logic [NUM_REGS-1:0] m_pend = '0;
    logic                m_err  = 1'b0;

    function automatic logic exp_a_ready();
        return !rst && bus.a_valid && (!bus.b_valid || m_last);
    endfunction

    function automatic logic exp_b_ready();
        return !rst && bus.b_valid && (!bus.a_valid || !m_last);
    endfunction

    task automatic idle();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.b_issue = 1'b0;
    endtask

    // Advance the reference model for the current inputs, queue the expected write, clock once.
    task automatic tick();
        logic ga, gb, x, ok;
        logic [3:0] d;
        logic [DATA_W-1:0] v;
        wb_exp_t e;
        ga = exp_a_ready();
        gb = exp_b_ready();
        x  = ga | gb;
        d  = ga ? bus.a_dest : bus.b_dest;
        v  = ga ? bus.a_value : bus.b_value;
        ok = int'(d) < NUM_REGS;
        e.chk_dv = 1'b1;
        if (rst) begin
            m_en = 1'b0; m_dest = '0; m_val = '0; m_pend = '0; m_err = 1'b0; m_last = 1'b1;
        end else begin
            m_en = x && ok;
            if (m_en) begin m_dest = d; m_val = v; end
            if (x && !ok) begin m_err = 1'b1; e.chk_dv = 1'b0; end
            if (ga) m_last = 1'b0; else if (gb) m_last = 1'b1;
            if (gb && int'(bus.b_dest) < NUM_REGS) m_pend[bus.b_dest] = 1'b0;
            if (bus.b_issue && int'(bus.b_issue_dest) < NUM_REGS) m_pend[bus.b_issue_dest] = 1'b1;
        end
        e.en = m_en; e.dest = m_dest; e.value = m_val;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        wb_exp_t e;
        idle();
        rst = 1'b1;
        tick();
        e = sb_q.pop_front();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        wb_exp_t e;
        rst = 1'b1;
        bus.a_valid = 1'b1; bus.a_dest = 4'd1; bus.a_value = 32'h1111;
        bus.b_valid = 1'b1; bus.b_dest = 4'd2; bus.b_value = 32'h2222;
        bus.b_issue = 1'b1; bus.b_issue_dest = 4'd3;
        #1;
        n_chk++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0)
            $display("FAIL reset_ready: a_ready=%b b_ready=%b want 0 0", bus.a_ready, bus.b_ready);
        else n_pass++;
        tick(); e = sb_q.pop_front();
        tick(); e = sb_q.pop_front();
        n_chk++;
        if ({bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value} !== {e.en, e.dest, e.value} || bus.WB_WB_EN !== 1'b0
            || bus.WB_Dest !== 4'd0 || bus.WB_Value !== '0)
            $display("FAIL reset_wb: en=%b dest=%0d val=%h want 0 0 0", bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value);
        else n_pass++;
        n_chk++;
        if (bus.pending !== '0 || bus.dest_err !== 1'b0)
            $display("FAIL reset_state: pending=%h dest_err=%b want 0 0", bus.pending, bus.dest_err);
        else n_pass++;
        rst = 1'b0;
        idle();
    endtask

    task automatic test_single_a();
        wb_exp_t e;
        bus.a_valid = 1'b1; bus.a_dest = 4'd3; bus.a_value = 32'hAA;
        #1;
        n_chk++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0)
            $display("FAIL single_ready: a_ready=%b b_ready=%b want 1 0", bus.a_ready, bus.b_ready);
        else n_pass++;
        tick();
        idle();
        e = sb_q.pop_front();
        n_chk++;
        if ({bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value} !== {e.en, e.dest, e.value} || bus.WB_Dest !== 4'd3)
            $display("FAIL single_wb: en=%b dest=%0d val=%h want %b %0d %h",
                     bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value, e.en, e.dest, e.value);
        else n_pass++;
        tick();
        e = sb_q.pop_front();
        n_chk++;
        if ({bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value} !== {e.en, e.dest, e.value} || bus.WB_WB_EN !== 1'b0)
            $display("FAIL single_hold: en=%b dest=%0d val=%h want %b %0d %h",
                     bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value, e.en, e.dest, e.value);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        wb_exp_t e;
        logic [3:0] a_wins;
        a_wins = 4'b0101;
        pulse_reset();
        bus.a_valid = 1'b1; bus.a_dest = 4'd1; bus.a_value = 32'h0000_0011;
        bus.b_valid = 1'b1; bus.b_dest = 4'd2; bus.b_value = 32'h0000_0022;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++;
            if (bus.a_ready !== a_wins[i] || bus.b_ready !== !a_wins[i])
                $display("FAIL rr_grant%0d: a_ready=%b b_ready=%b want %b %b",
                         i, bus.a_ready, bus.b_ready, a_wins[i], !a_wins[i]);
            else n_pass++;
            tick();
            e = sb_q.pop_front();
            n_chk++;
            if ({bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value} !== {e.en, e.dest, e.value}
                || bus.WB_Dest !== (a_wins[i] ? 4'd1 : 4'd2))
                $display("FAIL rr_wb%0d: en=%b dest=%0d val=%h want %b %0d %h",
                         i, bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value, e.en, e.dest, e.value);
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_pending();
        wb_exp_t e;
        bus.b_issue = 1'b1; bus.b_issue_dest = 4'd5;
        tick(); e = sb_q.pop_front();
        bus.b_issue = 1'b0;
        n_chk++;
        if (bus.pending !== 15'h0020) $display("FAIL pend_set: pending=%h want 0020", bus.pending);
        else n_pass++;
        bus.b_issue = 1'b1; bus.b_issue_dest = 4'd15;
        tick(); e = sb_q.pop_front();
        bus.b_issue = 1'b0;
        n_chk++;
        if (bus.pending !== 15'h0020) $display("FAIL pend_ignore15: pending=%h want 0020", bus.pending);
        else n_pass++;
        bus.a_valid = 1'b1; bus.a_dest = 4'd5; bus.a_value = 32'h5A5A;
        tick(); e = sb_q.pop_front();
        bus.a_valid = 1'b0;
        n_chk++;
        if (bus.pending !== 15'h0020 || bus.WB_WB_EN !== e.en || bus.WB_Value !== e.value)
            $display("FAIL pend_a_xfer: pending=%h en=%b val=%h want 0020 %b %h",
                     bus.pending, bus.WB_WB_EN, bus.WB_Value, e.en, e.value);
        else n_pass++;
        bus.b_valid = 1'b1; bus.b_dest = 4'd5; bus.b_value = 32'h55;
        #1;
        n_chk++;
        if (bus.b_ready !== 1'b1) $display("FAIL pend_b_ready: b_ready=%b want 1", bus.b_ready);
        else n_pass++;
        tick(); e = sb_q.pop_front();
        bus.b_valid = 1'b0;
        n_chk++;
        if (bus.pending !== 15'h0000 || {bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value} !== {e.en, e.dest, e.value})
            $display("FAIL pend_clear: pending=%h en=%b dest=%0d want 0000 %b %0d",
                     bus.pending, bus.WB_WB_EN, bus.WB_Dest, e.en, e.dest);
        else n_pass++;
    endtask

    task automatic test_issue_collision();
        wb_exp_t e;
        bus.b_issue = 1'b1; bus.b_issue_dest = 4'd7;
        tick(); e = sb_q.pop_front();
        bus.b_valid = 1'b1; bus.b_dest = 4'd7; bus.b_value = 32'h77;
        tick(); e = sb_q.pop_front();
        n_chk++;
        if (bus.pending !== 15'h0080) $display("FAIL coll_same: pending=%h want 0080", bus.pending);
        else n_pass++;
        bus.b_issue_dest = 4'd8;
        tick(); e = sb_q.pop_front();
        n_chk++;
        if (bus.pending !== 15'h0100) $display("FAIL coll_diff: pending=%h want 0100", bus.pending);
        else n_pass++;
        bus.b_issue = 1'b0; bus.b_dest = 4'd8; bus.b_value = 32'h88;
        tick(); e = sb_q.pop_front();
        idle();
        n_chk++;
        if (bus.pending !== 15'h0000 || bus.WB_Dest !== e.dest || bus.WB_Value !== e.value)
            $display("FAIL coll_drain: pending=%h dest=%0d val=%h want 0000 %0d %h",
                     bus.pending, bus.WB_Dest, bus.WB_Value, e.dest, e.value);
        else n_pass++;
    endtask

    task automatic test_dest_err();
        wb_exp_t e;
        bus.a_valid = 1'b1; bus.a_dest = 4'd15; bus.a_value = 32'hDEAD;
        #1;
        n_chk++;
        if (bus.a_ready !== 1'b1) $display("FAIL err_ready: a_ready=%b want 1", bus.a_ready);
        else n_pass++;
        tick(); e = sb_q.pop_front();
        idle();
        n_chk++;
        if (bus.WB_WB_EN !== 1'b0 || bus.WB_WB_EN !== e.en || bus.dest_err !== 1'b1)
            $display("FAIL err_flag: en=%b dest_err=%b want 0 1", bus.WB_WB_EN, bus.dest_err);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            tick(); e = sb_q.pop_front();
        end
        n_chk++;
        if (bus.dest_err !== 1'b1) $display("FAIL err_sticky: dest_err=%b want 1", bus.dest_err);
        else n_pass++;
    endtask

    task automatic test_reset_inflight();
        wb_exp_t e;
        bus.b_issue = 1'b1; bus.b_issue_dest = 4'd9;
        tick(); e = sb_q.pop_front();
        bus.b_issue = 1'b0;
        bus.b_valid = 1'b1; bus.b_dest = 4'd9; bus.b_value = 32'h99;
        #1;
        n_chk++;
        if (bus.b_ready !== 1'b1 || bus.pending !== 15'h0200)
            $display("FAIL rif_pre: b_ready=%b pending=%h want 1 0200", bus.b_ready, bus.pending);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.b_ready !== 1'b0) $display("FAIL rif_ready: b_ready=%b want 0", bus.b_ready);
        else n_pass++;
        tick(); e = sb_q.pop_front();
        rst = 1'b0;
        n_chk++;
        if (bus.WB_WB_EN !== 1'b0 || bus.pending !== '0 || bus.dest_err !== 1'b0)
            $display("FAIL rif_drop: en=%b pending=%h dest_err=%b want 0 0 0",
                     bus.WB_WB_EN, bus.pending, bus.dest_err);
        else n_pass++;
        bus.a_valid = 1'b1; bus.a_dest = 4'd6; bus.a_value = 32'h66;
        bus.b_dest = 4'd10; bus.b_value = 32'hA0;
        #1;
        n_chk++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0)
            $display("FAIL rif_grant: a_ready=%b b_ready=%b want 1 0", bus.a_ready, bus.b_ready);
        else n_pass++;
        tick(); e = sb_q.pop_front();
        idle();
        n_chk++;
        if ({bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value} !== {e.en, e.dest, e.value} || bus.WB_Dest !== 4'd6)
            $display("FAIL rif_wb: en=%b dest=%0d val=%h want 1 6 %h",
                     bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value, e.value);
        else n_pass++;
    endtask

    task automatic test_random();
        wb_exp_t e;
        for (int i = 0; i < 300; i++) begin
            rst              = ($urandom_range(0, 39) == 0);
            bus.a_valid      = 1'($urandom_range(0, 1));
            bus.a_dest       = 4'($urandom_range(0, 15));
            bus.a_value      = $urandom;
            bus.b_valid      = 1'($urandom_range(0, 1));
            bus.b_dest       = 4'($urandom_range(0, 15));
            bus.b_value      = $urandom;
            bus.b_issue      = 1'($urandom_range(0, 1));
            bus.b_issue_dest = 4'($urandom_range(0, 15));
            #1;
            n_chk++;
            if (bus.a_ready !== exp_a_ready() || bus.b_ready !== exp_b_ready())
                $display("FAIL rand_ready%0d: a_ready=%b b_ready=%b want %b %b",
                         i, bus.a_ready, bus.b_ready, exp_a_ready(), exp_b_ready());
            else n_pass++;
            tick();
            e = sb_q.pop_front();
            n_chk++;
            if (bus.WB_WB_EN !== e.en || (e.chk_dv && (bus.WB_Dest !== e.dest || bus.WB_Value !== e.value))
                || bus.pending !== m_pend || bus.dest_err !== m_err)
                $display("FAIL rand_out%0d: en=%b dest=%0d val=%h pend=%h err=%b want %b %0d %h %h %b",
                         i, bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value, bus.pending, bus.dest_err,
                         e.en, e.dest, e.value, m_pend, m_err);
            else n_pass++;
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        bus.a_valid = 1'b0; bus.a_dest = '0; bus.a_value = '0;
        bus.b_valid = 1'b0; bus.b_dest = '0; bus.b_value = '0;
        bus.b_issue = 1'b0; bus.b_issue_dest = '0;
        test_reset();
        test_single_a();
        test_round_robin();
        test_pending();
        test_issue_collision();
        test_dest_err();
        test_reset_inflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of write data.
REQ-002 Parameter NUM_REGS, default 15, number of architectural registers; legal destinations are 0..NUM_REGS-1.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port a_valid/a_dest/a_value  input  1/4/DATA_W  requester A (pipeline WB stage) write request.
REQ-006 Port a_ready  output  1  A request accepted this cycle.
REQ-007 Port b_valid/b_dest/b_value  input  1/4/DATA_W  requester B (multi-cycle unit) write request.
REQ-008 Port b_ready  output  1  B request accepted this cycle.
REQ-009 Port b_issue/b_issue_dest  input  1/4  B has started an operation targeting b_issue_dest.
REQ-010 Port WB_WB_EN/WB_Dest/WB_Value  output  1/4/DATA_W  registered write port driven to the register file.
REQ-011 Port pending  output  NUM_REGS  scoreboard: bit r set while a B write to r is outstanding.
REQ-012 Port dest_err  output  1  sticky flag: an accepted request had dest >= NUM_REGS.

Function
REQ-013 Transfer occurs on a requester when valid and ready are both 1 at a rising edge.
REQ-014 a_ready and b_ready are combinational from the valid inputs and last_grant; at most one is 1 per cycle.
REQ-015 Only one requester valid -> that requester's ready = 1.
REQ-016 Both valid -> grant the requester not granted last (round-robin on a 1-bit last_grant); neither valid -> last_grant holds.
REQ-017 The losing requester waits at most one cycle while the winner stays continuously valid.
REQ-018 The cycle after a transfer, WB_WB_EN = 1, and WB_Dest/WB_Value equal the accepted dest/value; latency is exactly 1 cycle.
REQ-019 No transfer -> WB_WB_EN = 0 next cycle; WB_Dest/WB_Value hold their previous values.
REQ-020 Registered outputs change only on rising edges, so they are stable for a negative-edge-write register file within the same cycle.
REQ-021 Accepted dest >= NUM_REGS -> ready still asserted, WB_WB_EN = 0 next cycle, dest_err set to 1 and held until reset.
REQ-022 b_issue with b_issue_dest < NUM_REGS -> pending[b_issue_dest] set next cycle; b_issue_dest >= NUM_REGS ignored.
REQ-023 B transfer with b_dest < NUM_REGS -> pending[b_dest] cleared next cycle.
REQ-024 b_issue and B transfer to the same dest in the same cycle -> bit ends set (issue wins).
REQ-025 b_issue and B transfer to different dests -> both updates apply.
REQ-026 A transfers do not modify pending.

Reset
REQ-027 rst = 1 at a rising edge -> WB_WB_EN=0, WB_Dest=0, WB_Value=0, pending=0, dest_err=0, last_grant=B (so A wins the first contention).
REQ-028 During a reset cycle, a_ready and b_ready are 0 and no transfer occurs.
REQ-029 Reset asserted with a transfer in flight -> the transfer is dropped and WB_WB_EN=0 the next cycle.

Verification
REQ-030 After reset, a_valid=1, a_dest=3, a_value=0xAA in one cycle -> a_ready=1; next cycle WB_WB_EN=1, WB_Dest=3, WB_Value=0xAA; following cycle WB_WB_EN=0.
REQ-031 a_valid and b_valid held high 4 cycles (A dest 1, B dest 2) -> grants A,B,A,B; WB_Dest 1,2,1,2 on cycles 2..5.
REQ-032 b_issue dest=5 -> pending=0x0020; a later B transfer dest=5 -> pending=0 the cycle after.
REQ-033 Same cycle b_issue dest=7 and B transfer dest=7 with pending[7]=1 -> pending[7] remains 1.
REQ-034 A transfer dest=15 -> a_ready=1, WB_WB_EN=0 next cycle, dest_err=1 and still 1 ten cycles later.
REQ-035 rst pulsed during a granted B transfer -> next cycle WB_WB_EN=0, pending=0, and a subsequent A/B contention grants A.
